// File: rtl/axi_master_wr.sv
// AXI4 write master: one INCR burst of 64-bit beats per start, data pulled from a show-ahead FIFO.
// Optional macro AXI_WR_BRESP_CHK_EN enables the sticky write-response error flag wr_err.
module axi_master_wr #(
    parameter int unsigned AXI_ID_WIDTH = 4,
    parameter int unsigned AXI_ID       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    axi_wr_start,
    input  logic [29:0]             axi_wr_addr,
    input  logic [7:0]              axi_wr_len,
    input  logic [63:0]             axi_wr_data,
    output logic                    axi_wr_ready,
    output logic                    axi_writing,
    output logic                    axi_wr_done,
    output logic                    wr_err,
    output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
    output logic [29:0]             m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [63:0]             m_axi_wdata,
    output logic [7:0]              m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0] m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WA   = 2'd1,
        WD   = 2'd2,
        WB   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                done_q, done_d;
    logic                w_hs_c;
    logic                last_beat_c;
    logic                unused_bits;

    assign w_hs_c      = wvalid_q & m_axi_wready;
    assign last_beat_c = (cnt_q == len_q);

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
        end
    end

    // Next state; valids/ready are decoded from the next state so they are flops.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (axi_wr_start) begin
                    addr_d  = axi_wr_addr;
                    len_d   = axi_wr_len;
                    cnt_d   = '0;
                    state_d = WA;
                end
            end
            WA: begin
                if (awvalid_q && m_axi_awready) begin
                    state_d = WD;
                end
            end
            WD: begin
                if (w_hs_c) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_beat_c) begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                if (bready_q && m_axi_bvalid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d   = (state_d == IDLE);
        awvalid_d = (state_d == WA);
        wvalid_d  = (state_d == WD);
        bready_d  = (state_d == WB);
    end

`ifdef AXI_WR_BRESP_CHK_EN
    logic err_q;

    // Sticky until reset; any non-OKAY response on a B handshake sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bready_q && m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign wr_err = err_q;
`else
    assign wr_err = 1'b0;
`endif

    assign unused_bits = ^{m_axi_bid, m_axi_bresp};

    assign axi_wr_ready  = ready_q;
    assign axi_wr_done   = done_q;
    assign axi_writing   = w_hs_c;

    assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'b011;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0010;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_q;

    // Show-ahead FIFO data goes straight out; the handshake itself is the FIFO pop.
    assign m_axi_wdata   = axi_wr_data;
    assign m_axi_wstrb   = 8'hFF;
    assign m_axi_wlast   = wvalid_q & last_beat_c;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_master_wr.sv
// Scoreboard bench for axi_master_wr: a FIFO/slave model drives the DUT, a negedge monitor checks it.
module tb_axi_master_wr;

    localparam int unsigned IDW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            axi_wr_start;
    logic [29:0]     axi_wr_addr;
    logic [7:0]      axi_wr_len;
    logic [63:0]     axi_wr_data;
    logic            axi_wr_ready, axi_writing, axi_wr_done, wr_err;
    logic [IDW-1:0]  m_axi_awid;
    logic [29:0]     m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awlock;
    logic [3:0]      m_axi_awcache;
    logic [2:0]      m_axi_awprot;
    logic [3:0]      m_axi_awqos;
    logic            m_axi_awvalid, m_axi_awready;
    logic [63:0]     m_axi_wdata;
    logic [7:0]      m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [IDW-1:0]  m_axi_bid;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid, m_axi_bready;

    axi_master_wr #(.AXI_ID_WIDTH(IDW), .AXI_ID(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_wr_start(axi_wr_start), .axi_wr_addr(axi_wr_addr), .axi_wr_len(axi_wr_len),
        .axi_wr_data(axi_wr_data), .axi_wr_ready(axi_wr_ready), .axi_writing(axi_writing),
        .axi_wr_done(axi_wr_done), .wr_err(wr_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard queues and environment models.
    logic [37:0] aw_q[$];
    logic [64:0] w_q[$];
    logic        done_q[$];
    logic [63:0] fifo[$];

    int   mode = 1;          // 0 random, 1 zero-wait, 2 delayed AW/B, 3 wready toggling
    logic [1:0] force_bresp = 2'b00;
    bit   pend_b, pop_pend, bset, bclr, toggle;
    int   aw_wait, b_wait;
    logic err_model;
    int   wr_count, done_count, aw_cyc;
    bit   aw_stall_prev, w_stall_prev;
    logic [37:0] aw_prev;
    logic [64:0] w_prev;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Slave + show-ahead FIFO, updated just after each rising edge.
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_bid = '0; axi_wr_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                pend_b = 0; pop_pend = 0; bset = 0; bclr = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                continue;
            end
            if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
            pop_pend = 0;
            if (bset) pend_b = 1;
            if (bclr) pend_b = 0;
            bset = 0; bclr = 0;
            if (m_axi_awvalid) aw_wait++; else aw_wait = 0;
            if (pend_b) b_wait++; else b_wait = 0;
            m_axi_bid = IDW'($urandom);
            case (mode)
                0: begin
                    m_axi_awready = 1'($urandom % 2);
                    m_axi_wready  = ($urandom % 3) != 0;
                    m_axi_bvalid  = pend_b && ($urandom % 2 == 0);
                    m_axi_bresp   = ($urandom % 4 == 0) ? 2'b10 : 2'b00;
                end
                2: begin
                    m_axi_awready = (aw_wait >= 6);
                    m_axi_wready  = 1;
                    m_axi_bvalid  = pend_b && (b_wait >= 4);
                    m_axi_bresp   = force_bresp;
                end
                3: begin
                    m_axi_awready = 1;
                    m_axi_wready  = toggle;
                    toggle        = ~toggle;
                    m_axi_bvalid  = pend_b;
                    m_axi_bresp   = force_bresp;
                end
                default: begin
                    m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = pend_b;
                    m_axi_bresp   = force_bresp;
                end
            endcase
            axi_wr_data = (fifo.size() > 0) ? fifo[0] : 64'h0;
        end
    end

    // Monitor: compares every handshake against the scoreboard at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_stall_prev = 0; w_stall_prev = 0; aw_cyc = 0;
                continue;
            end
            if (aw_stall_prev) begin
                chk("aw_hold_valid", m_axi_awvalid, 1'b1);
                chk("aw_hold_payload", {m_axi_awaddr, m_axi_awlen}, aw_prev);
            end
            if (m_axi_awvalid) aw_cyc++;
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL aw_unexpected: addr %0h with nothing expected", m_axi_awaddr);
                end else begin
                    chk("aw_payload", {m_axi_awaddr, m_axi_awlen}, aw_q.pop_front());
                    chk("aw_const", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                                     m_axi_awcache, m_axi_awprot, m_axi_awqos},
                        {4'd5, 3'b011, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
                end
                if (mode == 2) chk("aw_valid_cycles", aw_cyc, 6);
                aw_cyc = 0;
            end
            aw_stall_prev = m_axi_awvalid && !m_axi_awready;
            aw_prev = {m_axi_awaddr, m_axi_awlen};

            if (w_stall_prev) begin
                chk("w_hold_valid", m_axi_wvalid, 1'b1);
                chk("w_hold_data_last", {m_axi_wdata, m_axi_wlast}, w_prev);
            end
            if (m_axi_wvalid && m_axi_wready) begin
                chk("writing_on_hs", axi_writing, 1'b1);
                if (w_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL w_unexpected: data %0h with nothing expected", m_axi_wdata);
                end else begin
                    chk("w_beat", {m_axi_wdata, m_axi_wlast, m_axi_wstrb}, {w_q.pop_front(), 8'hFF});
                end
                if (m_axi_wlast) bset = 1;
            end else if (axi_writing) begin
                chk("writing_without_hs", axi_writing, 1'b0);
            end
            if (axi_writing) begin
                pop_pend = 1;
                wr_count++;
            end
            w_stall_prev = m_axi_wvalid && !m_axi_wready;
            w_prev = {m_axi_wdata, m_axi_wlast};

            if (pend_b && !m_axi_bvalid) chk("bready_waiting", m_axi_bready, 1'b1);
            if (m_axi_bvalid && m_axi_bready) begin
                bclr = 1;
`ifdef AXI_WR_BRESP_CHK_EN
                if (m_axi_bresp != 2'b00) err_model = 1'b1;
`endif
                done_q.push_back(err_model);
            end

            if (axi_wr_done) begin
                done_count++;
                if (done_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_unexpected: done pulse with no completed B handshake");
                end else begin
                    chk("wr_err_at_done", wr_err, done_q.pop_front());
                end
                chk("ready_at_done", axi_wr_ready, 1'b1);
            end
        end
    end

    task automatic issue(input logic [29:0] a, input logic [7:0] l);
        axi_wr_addr  = a;
        axi_wr_len   = l;
        axi_wr_start = 1;
        aw_q.push_back({a, l});
        for (int i = 0; i <= int'(l); i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            fifo.push_back(d);
            w_q.push_back({d, (i == int'(l))});
        end
        wr_count = 0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!axi_wr_ready && k < 2000) begin
            @(posedge clk); #1; k++;
        end
        if (!axi_wr_ready) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: ready still %0d after %0d cycles", axi_wr_ready, k);
        end
    endtask

    task automatic run(input bit hold, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (!hold) axi_wr_start = 0;
        end while (!axi_wr_done && n < 4000);
        if (!axi_wr_done) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no done after %0d cycles, got 0 required 1", n);
        end
    endtask

    initial begin
        int n;
        rst_n = 1; axi_wr_start = 0; axi_wr_addr = '0; axi_wr_len = '0;
        err_model = 0; done_count = 0; wr_count = 0;
        #3 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", axi_wr_ready, 1'b1);
        chk("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                             axi_writing, axi_wr_done, wr_err}, 7'b0);
        chk("reset_aw", {m_axi_awaddr, m_axi_awlen}, 38'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // Zero-wait 16 beats: done len+4 edges after start is presented.
        mode = 1;
        wait_ready(); issue(30'h100, 8'd15); run(0, n);
        chk("latency_len15", n, 19);
        chk("beats_len15", wr_count, 16);

        wait_ready(); issue(30'h3FFF_FFF8, 8'd0); run(0, n);
        chk("latency_len0", n, 4);
        chk("beats_len0", wr_count, 1);

        // wready toggling 1-0-1-0.
        mode = 3; toggle = 1;
        wait_ready(); issue(30'h2000, 8'd7); run(0, n);
        chk("beats_toggle", wr_count, 8);

        // AW held 6 cycles, B delayed.
        mode = 2;
        wait_ready(); issue(30'h4A8, 8'd3); run(0, n);
        chk("beats_delayed", wr_count, 4);

        // Back-to-back with start held high.
        mode = 1;
        wait_ready(); issue(30'h0, 8'd15); run(1, n);
        issue(30'd128, 8'd15);
        @(posedge clk); #1;
        chk("b2b_awvalid", m_axi_awvalid, 1'b1);
        chk("b2b_awaddr", m_axi_awaddr, 30'd128);
        axi_wr_start = 0;
        run(0, n);

        // Error response followed by an OKAY burst.
        force_bresp = 2'b10;
        wait_ready(); issue(30'h800, 8'd2); run(0, n);
        force_bresp = 2'b00;
        wait_ready(); issue(30'h900, 8'd2); run(0, n);
`ifdef AXI_WR_BRESP_CHK_EN
        chk("wr_err_sticky", wr_err, 1'b1);
`else
        chk("wr_err_tied", wr_err, 1'b0);
`endif

        // Reset mid-burst.
        wait_ready(); issue(30'h200, 8'd15);
        begin
            int k = 0;
            do begin
                @(posedge clk); #1; k++; axi_wr_start = 0;
            end while (wr_count < 4 && k < 200);
        end
        n = done_count;
        rst_n = 0; #1;
        chk("rst_mid_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, axi_wr_done, wr_err}, 5'b0);
        chk("rst_mid_ready", axi_wr_ready, 1'b1);
        aw_q.delete(); w_q.delete(); done_q.delete(); fifo.delete();
        err_model = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_ready_after", axi_wr_ready, 1'b1);
        chk("rst_mid_no_done", done_count, n);

        // Randomized bursts against a randomized slave.
        mode = 0;
        for (int b = 0; b < 40; b++) begin
            logic [29:0] a;
            a = {27'($urandom), 3'b000};
            wait_ready();
            repeat ($urandom % 3) begin @(posedge clk); #1; end
            issue(a, 8'($urandom % 21));
            run(0, n);
            chk("rand_beats", wr_count, int'(axi_wr_len) + 1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", {aw_q.size(), w_q.size(), done_q.size()}, 96'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
